// File: rtl/pc_fetch.sv
// pc_fetch: program-counter and instruction-fetch front end.
// Tracks the fetch PC, issues requests to instruction memory, absorbs
// memory wait states, applies branch/jalr redirects (deferring them while
// a fetch is outstanding), and traps on misaligned redirect targets.
//
// Handshake: a fetch transfers in any cycle where imem_req and imem_ready
// are both high. Once imem_req is raised in WAIT, it and imem_addr hold
// steady until imem_ready is seen.
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] branch_target,
    input  logic [31:0] jalr_target,
    input  logic        stall,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        if_valid,
    output logic        flush,
    output logic        misalign_trap,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_TRAP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_pc_q, pend_pc_d;     // redirect target waiting on the outstanding fetch
    logic        pend_vld_q, pend_vld_d;
    logic        pend_trap_q, pend_trap_d; // misaligned redirect seen while waiting
    logic        discard_q, discard_d;     // outstanding fetch belongs to a redirected path
    logic        trap_q, trap_d;

    logic        redirect;
    logic        tgt_misalign;
    logic [31:0] target;
    logic [31:0] pc_inc;
    logic        req_c, valid_c, flush_c;

    // Decode the redirect request and its target (PCSrc=11 acts as sequential).
    always_comb begin
        redirect     = (PCSrc == 2'b01) || (PCSrc == 2'b10);
        target       = (PCSrc == 2'b10) ? {jalr_target[31:1], 1'b0} : branch_target;
        tgt_misalign = (target[1:0] != 2'b00);
        pc_inc       = pc_q + 32'd4;
    end

    // Next-state, next-PC and per-cycle handshake outputs.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_pc_d   = pend_pc_q;
        pend_vld_d  = pend_vld_q;
        pend_trap_d = pend_trap_q;
        discard_d   = discard_q;
        trap_d      = trap_q;
        req_c       = 1'b0;
        valid_c     = 1'b0;
        flush_c     = 1'b0;

        case (state_q)
            S_BOOT: begin
                state_d = S_FETCH;
                if (redirect) begin
                    flush_c = 1'b1;
                    if (tgt_misalign) begin
                        trap_d  = 1'b1;
                        state_d = S_TRAP;
                    end else begin
                        pc_d = target;
                    end
                end
            end

            S_FETCH: begin
                req_c = !stall;
                if (redirect) begin
                    // Redirect wins over stall; any same-cycle transfer is dropped.
                    flush_c = 1'b1;
                    if (tgt_misalign) begin
                        trap_d  = 1'b1;
                        state_d = S_TRAP;
                    end else begin
                        pc_d = target;
                    end
                end else if (!stall) begin
                    if (imem_ready) begin
                        valid_c = 1'b1;
                        pc_d    = pc_inc;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end

            S_WAIT: begin
                // Request and address stay put; stall has no effect here.
                req_c = 1'b1;
                if (redirect) begin
                    flush_c   = 1'b1;
                    discard_d = 1'b1;
                    if (tgt_misalign) begin
                        trap_d      = 1'b1;
                        pend_trap_d = 1'b1;
                    end else begin
                        pend_pc_d  = target;
                        pend_vld_d = 1'b1;
                    end
                end
                if (imem_ready) begin
                    valid_c     = !(discard_q || redirect);
                    state_d     = S_FETCH;
                    pend_vld_d  = 1'b0;
                    pend_trap_d = 1'b0;
                    discard_d   = 1'b0;
                    if (pend_trap_q || (redirect && tgt_misalign)) begin
                        state_d = S_TRAP;
                    end else if (redirect) begin
                        pc_d = target;
                    end else if (pend_vld_q) begin
                        pc_d = pend_pc_q;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end

            S_TRAP: begin
                // Parked until reset.
            end

            default: state_d = S_BOOT;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_BOOT;
            pc_q        <= RESET_PC;
            pend_pc_q   <= 32'h0;
            pend_vld_q  <= 1'b0;
            pend_trap_q <= 1'b0;
            discard_q   <= 1'b0;
            trap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_pc_q   <= pend_pc_d;
            pend_vld_q  <= pend_vld_d;
            pend_trap_q <= pend_trap_d;
            discard_q   <= discard_d;
            trap_q      <= trap_d;
        end
    end

    // Handshake pulses are suppressed while reset is asserted.
    always_comb begin
        imem_req      = rst_n & req_c;
        if_valid      = rst_n & valid_c;
        flush         = rst_n & flush_c;
        imem_addr     = pc_q;
        pc            = pc_q;
        pc_plus4      = pc_inc;
        misalign_trap = trap_q;
        dbg_state     = state_q;
    end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, address of the first fetch after reset.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 PCSrc  input  2  next-PC select from branch logic: 00 sequential, 01 branch/jal target, 10 jalr target, 11 reserved.
REQ-005 branch_target  input  32  PC+imm target, used when PCSrc=01.
REQ-006 jalr_target  input  32  rs1+imm target, used when PCSrc=10.
REQ-007 stall  input  1  hazard hold request from the pipeline.
REQ-008 imem_ready  input  1  instruction memory accepts imem_addr this cycle.
REQ-009 imem_req  output  1  fetch request to instruction memory.
REQ-010 imem_addr  output  32  fetch address; equals pc.
REQ-011 pc  output  32  current fetch PC.
REQ-012 pc_plus4  output  32  pc+4, modulo 2^32.
REQ-013 if_valid  output  1  one-cycle pulse: the instruction fetched at pc is valid for decode.
REQ-014 flush  output  1  one-cycle pulse: discard younger in-flight instructions after a redirect.
REQ-015 misalign_trap  output  1  sticky flag: a redirect target was not 4-byte aligned.

Function
REQ-016 The block SHALL implement states BOOT, FETCH, WAIT and TRAP.
REQ-017 BOOT: imem_req=0; the block SHALL move to FETCH on the next cycle.
REQ-018 FETCH: imem_req=1 unless stall=1; transfer when imem_req&imem_ready; imem_req&!imem_ready -> WAIT.
REQ-019 WAIT: imem_req=1 and imem_addr SHALL stay stable until imem_ready=1, then return to FETCH; stall is ignored in WAIT.
REQ-020 A transfer SHALL make pc<=pc_plus4 next cycle and pulse if_valid in the transfer cycle, unless the fetch is marked discarded.
REQ-021 Redirect = PCSrc of 01 or 10; PCSrc=11 SHALL behave as 00.
REQ-022 Redirect target SHALL be branch_target for 01, and jalr_target with bit0 forced to 0 for 10.
REQ-023 Redirect in FETCH or BOOT: pc<=target next cycle, flush=1 in the redirect cycle, if_valid=0 that cycle, and any transfer that cycle is discarded.
REQ-024 Redirect in WAIT: the target SHALL be latched in a pending register, flush=1 that cycle, the outstanding fetch is marked discarded, and pc<=pending target in the cycle after imem_ready=1.
REQ-025 A second redirect while one is pending SHALL overwrite the pending target.
REQ-026 Redirect SHALL take priority over stall; stall alone SHALL hold pc and drop imem_req in FETCH.
REQ-027 A redirect target with bits[1:0]!=00 after bit0 clearing SHALL set misalign_trap and enter TRAP instead of updating pc.
REQ-028 If that misaligned redirect occurs in WAIT, the outstanding fetch SHALL complete first, and the block SHALL then enter TRAP.
REQ-029 TRAP: imem_req=0, if_valid=0, and pc holds its value; only reset SHALL leave TRAP.
REQ-030 pc_plus4 SHALL wrap: pc=32'hFFFF_FFFC gives pc_plus4=32'h0000_0000, and a sequential fetch continues at 0.

Reset
REQ-031 While rst_n=0 at a clock edge: state=BOOT, pc=RESET_PC, pending cleared, misalign_trap=0.
REQ-032 While in reset: imem_req=0, if_valid=0, flush=0.
REQ-033 Reset mid-WAIT SHALL abandon the outstanding fetch without an if_valid pulse.

Verification
REQ-034 Sequential fetch: reset release, imem_ready=1, PCSrc=00 -> BOOT for 1 cycle; pc then reads 0,4,8,12 on consecutive cycles with if_valid=1 each.
REQ-035 Branch: at pc=8, PCSrc=01, branch_target=0x100 -> flush=1 and if_valid=0 that cycle; next pc=0x100.
REQ-036 JALR in WAIT: imem_ready=0 at pc=0x20, PCSrc=10, jalr_target=0x41 -> flush=1 and pending target=0x40; after imem_ready=1, no if_valid pulse and pc=0x40.
REQ-037 Misalign: PCSrc=01, branch_target=0x102 -> misalign_trap=1 and imem_req=0 from the next cycle; pc unchanged until rst_n=0.
REQ-038 Stall vs redirect: stall=1 holds pc=0x10 for 3 cycles with imem_req=0; stall=1 with PCSrc=01 and target=0x80 -> pc=0x80.
REQ-039 Wrap: redirect to 0xFFFF_FFFC, then imem_ready=1 -> next pc=0x0000_0000; reset mid-WAIT -> pc=RESET_PC with no if_valid pulse.
